// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcode map, ALU codes,
// sequencer states, opcode classes and the bundled control-strobe word.
package cpu_pkg;

    localparam int OPW = 5;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    // ALU function codes share the encoding of the matching R-type opcodes
    localparam logic [4:0] ALU_ADD = 5'd3;
    localparam logic [4:0] ALU_SUB = 5'd4;
    localparam logic [4:0] ALU_AND = 5'd5;
    localparam logic [4:0] ALU_OR  = 5'd6;
    localparam logic [4:0] ALU_MUL = 5'd14;
    localparam logic [4:0] ALU_DIV = 5'd15;
    localparam logic [4:0] ALU_NEG = 5'd16;
    localparam logic [4:0] ALU_NOT = 5'd17;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_RALU, CLS_IALU, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST,
        CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } cls_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout, cout;
        logic irin, pcin, pcout, incpc;
        logic marin, mdrin, mdrout, read, write;
        logic yin, zin, zhighout, zlowout;
        logic hiin, loin, hiout, loout;
        logic inportout, outportin, conin;
    } ctrl_t;

endpackage

// File: rtl/opcode_classifier.sv
// Maps an instruction opcode onto the execute-sequence class it follows.
module opcode_classifier
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output cls_t           cls
);

    always_comb begin
        cls = CLS_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_RALU;
            OP_ADDI, OP_ANDI, OP_ORI:       cls = CLS_IALU;
            OP_NEG, OP_NOT:                 cls = CLS_UNARY;
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
            OP_LD:                          cls = CLS_LD;
            OP_LDI:                         cls = CLS_LDI;
            OP_ST:                          cls = CLS_ST;
            OP_BR:                          cls = CLS_BR;
            OP_JR:                          cls = CLS_JR;
            OP_IN:                          cls = CLS_IN;
            OP_OUT:                         cls = CLS_OUT;
            OP_MFHI:                        cls = CLS_MFHI;
            OP_MFLO:                        cls = CLS_MFLO;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode-class execute steps T3-T7,
// memory handshake on mem_ready, HALT absorbing until clr.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        IRin,
    output logic        PCin,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        CONin,
    output logic [4:0]  alu_op,
    output logic        run
);

    state_t         state, state_nxt;
    cls_t           cls_dec, cls_q, cls;
    logic [OPW-1:0] op_q, op;
    logic           t1_wait;
    ctrl_t          c;
    logic           unused_ir;

    assign unused_ir = ^ir[31-OPW:0];

    opcode_classifier #(.OPW(OPW)) u_classifier (
        .opcode (ir[31 -: OPW]),
        .cls    (cls_dec)
    );

    // In T3 the freshly loaded IR is decoded live; later steps use the latched copy
    assign cls = (state == T3) ? cls_dec : cls_q;
    assign op  = (state == T3) ? ir[31 -: OPW] : op_q;

    function automatic logic [4:0] ialu_fn(input logic [OPW-1:0] opc);
        case (opc)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= RST;
            cls_q   <= CLS_NOP;
            op_q    <= '0;
            t1_wait <= 1'b0;
        end else begin
            state   <= state_nxt;
            t1_wait <= (state == T1);
            if (state == T3) begin
                cls_q <= cls_dec;
                op_q  <= ir[31 -: OPW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST: state_nxt = T0;
            T0:  state_nxt = T1;
            T1:  state_nxt = mem_ready ? T2 : T1;
            T2:  state_nxt = T3;
            T3: begin
                case (cls)
                    CLS_HALT: state_nxt = HALT;
                    CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP: state_nxt = T0;
                    default:  state_nxt = T4;
                endcase
            end
            T4: state_nxt = (cls == CLS_UNARY) ? T0 : T5;
            T5: begin
                case (cls)
                    CLS_RALU, CLS_IALU, CLS_LDI: state_nxt = T0;
                    default:                     state_nxt = T6;
                endcase
            end
            T6: begin
                case (cls)
                    CLS_LD:  state_nxt = mem_ready ? T7 : T6;
                    CLS_ST:  state_nxt = T7;
                    default: state_nxt = T0;
                endcase
            end
            T7: begin
                if (cls == CLS_ST) state_nxt = mem_ready ? T0 : T7;
                else               state_nxt = T0;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RST;
        endcase
    end

    always_comb begin
        c      = '0;
        alu_op = ALU_ADD;
        run    = 1'b1;
        case (state)
            T0: begin
                c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1;
            end
            T1: begin
                // PC update happens once even if memory stretches the read
                c.zlowout = 1'b1; c.pcin = !t1_wait; c.read = 1'b1; c.mdrin = 1'b1;
            end
            T2: begin
                c.mdrout = 1'b1; c.irin = 1'b1;
            end
            T3: begin
                case (cls)
                    CLS_RALU, CLS_IALU: begin c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
                    CLS_UNARY: begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; alu_op = op; end
                    CLS_MULDIV: begin c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
                    CLS_LD, CLS_LDI, CLS_ST: begin c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1; end
                    CLS_BR:   begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
                    CLS_JR:   begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
                    CLS_IN:   begin c.inportout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.outportin = 1'b1; end
                    CLS_MFHI: begin c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_MFLO: begin c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_RALU:   begin c.grc = 1'b1; c.rout = 1'b1; c.zin = 1'b1; alu_op = op; end
                    CLS_IALU:   begin c.cout = 1'b1; c.zin = 1'b1; alu_op = ialu_fn(op); end
                    CLS_UNARY:  begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_MULDIV: begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; alu_op = op; end
                    CLS_LD, CLS_LDI, CLS_ST: begin c.cout = 1'b1; c.zin = 1'b1; end
                    CLS_BR:     begin c.pcout = 1'b1; c.yin = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (cls)
                    CLS_RALU, CLS_IALU, CLS_LDI: begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_MULDIV:     begin c.zlowout = 1'b1; c.loin = 1'b1; end
                    CLS_LD, CLS_ST: begin c.zlowout = 1'b1; c.marin = 1'b1; end
                    CLS_BR:         begin c.cout = 1'b1; c.zin = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                case (cls)
                    CLS_MULDIV: begin c.zhighout = 1'b1; c.hiin = 1'b1; end
                    CLS_LD:     begin c.read = 1'b1; c.mdrin = 1'b1; end
                    CLS_ST:     begin c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1; end
                    CLS_BR:     begin c.zlowout = con_ff; c.pcin = con_ff; end
                    default: ;
                endcase
            end
            T7: begin
                case (cls)
                    CLS_LD:  begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    CLS_ST:  c.write = 1'b1;
                    default: ;
                endcase
            end
            HALT:    run = 1'b0;
            default: ;
        endcase
    end

    assign Gra       = c.gra;
    assign Grb       = c.grb;
    assign Grc       = c.grc;
    assign Rin       = c.rin;
    assign Rout      = c.rout;
    assign BAout     = c.baout;
    assign Cout      = c.cout;
    assign IRin      = c.irin;
    assign PCin      = c.pcin;
    assign PCout     = c.pcout;
    assign IncPC     = c.incpc;
    assign MARin     = c.marin;
    assign MDRin     = c.mdrin;
    assign MDRout    = c.mdrout;
    assign Read      = c.read;
    assign Write     = c.write;
    assign Yin       = c.yin;
    assign Zin       = c.zin;
    assign Zhighout  = c.zhighout;
    assign Zlowout   = c.zlowout;
    assign HIin      = c.hiin;
    assign LOin      = c.loin;
    assign HIout     = c.hiout;
    assign LOout     = c.loout;
    assign InPortout = c.inportout;
    assign OutPortin = c.outportin;
    assign CONin     = c.conin;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a per-instruction expectation queue built from
// the step tables, replayed cycle by cycle against the DUT outputs.
module tb_control_sequencer;

    localparam logic [26:0] GRA = 27'h1 << 0,   GRB = 27'h1 << 1,   GRC = 27'h1 << 2;
    localparam logic [26:0] RIN = 27'h1 << 3,   ROUT = 27'h1 << 4,  BAOUT = 27'h1 << 5;
    localparam logic [26:0] COUT = 27'h1 << 6,  IRIN = 27'h1 << 7,  PCIN = 27'h1 << 8;
    localparam logic [26:0] PCOUT = 27'h1 << 9, INCPC = 27'h1 << 10, MARIN = 27'h1 << 11;
    localparam logic [26:0] MDRIN = 27'h1 << 12, MDROUT = 27'h1 << 13, READ = 27'h1 << 14;
    localparam logic [26:0] WRITE = 27'h1 << 15, YIN = 27'h1 << 16, ZIN = 27'h1 << 17;
    localparam logic [26:0] ZHIGHOUT = 27'h1 << 18, ZLOWOUT = 27'h1 << 19, HIIN = 27'h1 << 20;
    localparam logic [26:0] LOIN = 27'h1 << 21, HIOUT = 27'h1 << 22, LOOUT = 27'h1 << 23;
    localparam logic [26:0] INPORTOUT = 27'h1 << 24, OUTPORTIN = 27'h1 << 25, CONIN = 27'h1 << 26;
    localparam logic [26:0] BUS_MASK = PCOUT | ZLOWOUT | ZHIGHOUT | MDROUT | ROUT | BAOUT |
                                       COUT | HIOUT | LOOUT | INPORTOUT;
    localparam logic [4:0] A_ADD = 5'd3, A_AND = 5'd5, A_OR = 5'd6;

    logic        clk, clr, con_ff, mem_ready;
    logic [31:0] ir;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, IRin, PCin, PCout, IncPC;
    logic MARin, MDRin, MDRout, Read, Write, Yin, Zin, Zhighout, Zlowout;
    logic HIin, LOin, HIout, LOout, InPortout, OutPortin, CONin, run;
    logic [4:0]  alu_op;
    logic [26:0] obs;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .IRin(IRin), .PCin(PCin), .PCout(PCout), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .InPortout(InPortout), .OutPortin(OutPortin), .CONin(CONin),
        .alu_op(alu_op), .run(run)
    );

    assign obs = {CONin, OutPortin, InPortout, LOout, HIout, LOin, HIin, Zlowout, Zhighout,
                  Zin, Yin, Write, Read, MDRout, MDRin, MARin, IncPC, PCout, PCin, IRin,
                  Cout, BAout, Rout, Rin, Grc, Grb, Gra};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ir;
        logic        con;
        logic        mr;
        logic [26:0] s;
        logic [4:0]  alu;
        logic        run;
        logic        rstc;
        logic        abort;
    } ent_t;

    ent_t        q[$];
    logic [31:0] cur_ir;
    logic        cur_con;
    int          checks, errors;
    int          n_read, n_pcin, n_write, n_run0;

    task automatic push(input logic [26:0] s, input logic [4:0] alu, input logic mr, input logic rn);
        ent_t e;
        e = '0;
        e.ir = cur_ir; e.con = cur_con; e.mr = mr; e.s = s; e.alu = alu; e.run = rn;
        q.push_back(e);
    endtask

    task automatic push_rst();
        ent_t e;
        e = '0;
        e.ir = cur_ir; e.alu = A_ADD; e.run = 1'b1; e.rstc = 1'b1;
        q.push_back(e);
    endtask

    // Expected cycle list for one instruction; w1/wm are memory wait states
    task automatic build(input int w1, input int wm);
        logic [4:0] op;
        op = cur_ir[31:27];
        push(PCOUT | MARIN | INCPC | ZIN, A_ADD, 1'b0, 1'b1);
        for (int i = 0; i <= w1; i++)
            push(ZLOWOUT | READ | MDRIN | ((i == 0) ? PCIN : 27'h0), A_ADD, (i == w1), 1'b1);
        push(MDROUT | IRIN, A_ADD, 1'b0, 1'b1);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
                push(GRB | ROUT | YIN, A_ADD, 1'b0, 1'b1);
                push(GRC | ROUT | ZIN, op, 1'b0, 1'b1);
                push(ZLOWOUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
            end
            5'd11, 5'd12, 5'd13: begin
                push(GRB | ROUT | YIN, A_ADD, 1'b0, 1'b1);
                push(COUT | ZIN, (op == 5'd11) ? A_ADD : (op == 5'd12) ? A_AND : A_OR, 1'b0, 1'b1);
                push(ZLOWOUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
            end
            5'd16, 5'd17: begin
                push(GRB | ROUT | ZIN, op, 1'b0, 1'b1);
                push(ZLOWOUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
            end
            5'd14, 5'd15: begin
                push(GRA | ROUT | YIN, A_ADD, 1'b0, 1'b1);
                push(GRB | ROUT | ZIN, op, 1'b0, 1'b1);
                push(ZLOWOUT | LOIN, A_ADD, 1'b0, 1'b1);
                push(ZHIGHOUT | HIIN, A_ADD, 1'b0, 1'b1);
            end
            5'd0, 5'd1, 5'd2: begin
                push(GRB | BAOUT | YIN, A_ADD, 1'b0, 1'b1);
                push(COUT | ZIN, A_ADD, 1'b0, 1'b1);
                if (op == 5'd1) push(ZLOWOUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
                else push(ZLOWOUT | MARIN, A_ADD, 1'b0, 1'b1);
                if (op == 5'd0) begin
                    for (int i = 0; i <= wm; i++) push(READ | MDRIN, A_ADD, (i == wm), 1'b1);
                    push(MDROUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
                end
                if (op == 5'd2) begin
                    push(GRA | ROUT | MDRIN, A_ADD, 1'b0, 1'b1);
                    for (int i = 0; i <= wm; i++) push(WRITE, A_ADD, (i == wm), 1'b1);
                end
            end
            5'd18: begin
                push(GRA | ROUT | CONIN, A_ADD, 1'b0, 1'b1);
                push(PCOUT | YIN, A_ADD, 1'b0, 1'b1);
                push(COUT | ZIN, A_ADD, 1'b0, 1'b1);
                push(cur_con ? (ZLOWOUT | PCIN) : 27'h0, A_ADD, 1'b0, 1'b1);
            end
            5'd19: push(GRA | ROUT | PCIN, A_ADD, 1'b0, 1'b1);
            5'd21: push(INPORTOUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
            5'd22: push(GRA | ROUT | OUTPORTIN, A_ADD, 1'b0, 1'b1);
            5'd23: push(HIOUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
            5'd24: push(LOOUT | GRA | RIN, A_ADD, 1'b0, 1'b1);
            5'd26: begin
                push(27'h0, A_ADD, 1'b0, 1'b1);
                for (int i = 0; i < 20; i++) push(27'h0, A_ADD, 1'b0, 1'b0);
            end
            default: push(27'h0, A_ADD, 1'b0, 1'b1);
        endcase
    endtask

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input ent_t e);
        @(posedge clk);
        #1;
        ir = e.ir; con_ff = e.con; mem_ready = e.mr;
        if (e.rstc) clr = 1'b1;
        #1;
        checks++;
        if (obs !== e.s || alu_op !== e.alu || run !== e.run) begin
            errors++;
            $display("FAIL cycle @%0t: strobes %h alu %b run %b, expected strobes %h alu %b run %b",
                     $time, obs, alu_op, run, e.s, e.alu, e.run);
        end
        chk("bus_exclusive", $countones(obs & BUS_MASK) <= 1, $countones(obs & BUS_MASK), 1);
        if (Read)  n_read++;
        if (PCin)  n_pcin++;
        if (Write) n_write++;
        if (!run)  n_run0++;
        if (e.rstc) clr = 1'b0;
        if (e.abort) begin
            #2;
            clr = 1'b1;
            #1;
            checks++;
            if (obs !== 27'h0 || alu_op !== A_ADD || run !== 1'b1) begin
                errors++;
                $display("FAIL abort_clear @%0t: strobes %h alu %b run %b, expected strobes 0 alu 00011 run 1",
                         $time, obs, alu_op, run);
            end
            clr = 1'b0;
        end
    endtask

    task automatic run_all();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            step(e);
        end
    endtask

    task automatic clear_counts();
        n_read = 0; n_pcin = 0; n_write = 0; n_run0 = 0;
    endtask

    logic [31:0] tbl [19];
    ent_t        last;

    initial begin
        checks = 0; errors = 0;
        clr = 1'b1; ir = '0; con_ff = 1'b0; mem_ready = 1'b0;
        cur_ir = '0; cur_con = 1'b0;
        clear_counts();

        push_rst();
        run_all();

        // add R1,R2,R3: six cycles after RST, T4 carries the add code
        cur_ir = 32'h18918000;
        build(0, 0);
        chk("model_len_add", q.size() == 6, q.size(), 6);
        chk("model_alu_add", q[4].alu == 5'b00011, int'(q[4].alu), 3);
        run_all();

        // ld with 3 wait states in T1 and 2 in T6
        cur_ir = 32'h00800055;
        build(3, 2);
        chk("model_len_ld", q.size() == 13, q.size(), 13);
        clear_counts();
        run_all();
        chk("ld_read_cycles", n_read == 7, n_read, 7);
        chk("ld_pcin_cycles", n_pcin == 1, n_pcin, 1);

        cur_ir = 32'h90800010; cur_con = 1'b0;
        build(0, 0);
        clear_counts();
        run_all();
        chk("br_nottaken_pcin", n_pcin == 1, n_pcin, 1);

        cur_con = 1'b1;
        build(1, 0);
        clear_counts();
        run_all();
        chk("br_taken_pcin", n_pcin == 2, n_pcin, 2);
        cur_con = 1'b0;

        cur_ir = 32'h71180000;
        build(0, 0);
        chk("model_len_mul", q.size() == 7, q.size(), 7);
        run_all();

        tbl = '{32'h20912345, 32'h28912345, 32'h30912345, 32'h38912345, 32'h40912345,
                32'h48912345, 32'h50912345, 32'h58912345, 32'h60912345, 32'h68912345,
                32'h78912345, 32'h80912345, 32'h88912345, 32'h08912345, 32'h98912345,
                32'hA8912345, 32'hB0912345, 32'hB8912345, 32'hC0912345};
        foreach (tbl[i]) begin
            cur_ir = tbl[i];
            build(i % 2, 0);
            run_all();
        end
        foreach (tbl[i]) begin
            cur_ir = {tbl[i][31:27] ^ 5'b00000, tbl[i][26:0]};
            if (i == 0) cur_ir = 32'hC8000000;
            if (i == 1) cur_ir = 32'hA0000000;
            if (i == 2) cur_ir = 32'hD8000000;
            if (i == 3) cur_ir = 32'h10800020;
            if (i > 3) break;
            build(1, 2);
            run_all();
        end

        // st aborted by clr while in T6: no Write may ever appear
        cur_ir = 32'h10800020;
        build(0, 0);
        last = q.pop_back();
        last = q.pop_back();
        chk("model_st_t6", last.s == (GRA | ROUT | MDRIN), int'(last.s), int'(GRA | ROUT | MDRIN));
        last.abort = 1'b1;
        q.push_back(last);
        clear_counts();
        run_all();
        chk("abort_no_write", n_write == 0, n_write, 0);

        cur_ir = 32'h18918000;
        build(0, 0);
        run_all();

        cur_ir = 32'hD0000000;
        build(0, 0);
        clear_counts();
        run_all();
        chk("halt_run_low", n_run0 == 20, n_run0, 20);

        push_rst();
        cur_ir = 32'h18918000;
        build(0, 0);
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit, 16-register datapath. It drives the control signals that the instruction register's select/encode logic consumes: Gra, Grb, Grc, Rin, Rout, BAout and IRin.
- It also drives the remaining bus, ALU, memory and I/O strobes.
- Sequence per instruction: fetch (T0–T2), then opcode-dependent execute steps (T3–T7). Memory reads and writes use a ready handshake.

Parameters:
- OPW, 5, opcode width (IR[31:27]).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- ir  in  32  current IR contents; only ir[31:27] is used.
- con_ff  in  1  branch-condition flip-flop output.
- mem_ready  in  1  memory has completed the current Read/Write.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes to the IR select/encode logic.
- Cout  out  1  sign-extended C onto the bus.
- IRin, PCin, PCout, IncPC  out  1 each  IR/PC strobes.
- MARin, MDRin, MDRout, Read, Write  out  1 each  memory-interface strobes.
- Yin, Zin, Zhighout, Zlowout  out  1 each  ALU operand/result strobes.
- HIin, LOin, HIout, LOout  out  1 each  HI/LO register strobes.
- InPortout, OutPortin, CONin  out  1 each  I/O and branch-condition strobes.
- alu_op  out  5  ALU function code.
- run  out  1  processor running; 0 only in HALT.

Behaviour:
- State register is reset asynchronously by clr to RST. All strobes are decoded combinationally from state and latched opcode class.
- In RST: every strobe = 0, alu_op = ALU_ADD, run = 1. RST -> T0 on the next clk after clr deasserts.
- clr asserted mid-instruction: strobes go to 0 immediately, sequence aborts, and execution resumes from RST.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold T1 while mem_ready = 0. PCin is asserted only in the first T1 cycle; Read and MDRin stay high in every waited cycle.
  - T2: MDRout, IRin.
- Opcode class is decoded from ir[31:27] in T3, the cycle after IRin, and held until T0.
- alu_op = ALU_ADD except in the ALU steps listed below.
- Execute steps, by class (each ends -> T0 unless stated):
  - R-ALU (add, sub, and, or, shr, shl, ror, rol):
    - T3 Grb Rout Yin.
    - T4 Grc Rout Zin, alu_op = opcode.
    - T5 Zlowout Gra Rin.
  - I-ALU (addi, andi, ori):
    - T3 Grb Rout Yin.
    - T4 Cout Zin, alu_op = ADD / AND / OR respectively.
    - T5 Zlowout Gra Rin.
  - Unary (neg, not):
    - T3 Grb Rout Zin, alu_op = opcode.
    - T4 Zlowout Gra Rin.
  - mul/div:
    - T3 Gra Rout Yin.
    - T4 Grb Rout Zin, alu_op = opcode.
    - T5 Zlowout LOin.
    - T6 Zhighout HIin.
  - ld:
    - T3 Grb BAout Yin.
    - T4 Cout Zin (ADD).
    - T5 Zlowout MARin.
    - T6 Read MDRin; hold while mem_ready = 0.
    - T7 MDRout Gra Rin.
  - ldi: T3 and T4 as ld, then T5 Zlowout Gra Rin.
  - st:
    - T3–T5 as ld.
    - T6 Gra Rout MDRin.
    - T7 Write; hold while mem_ready = 0.
  - br:
    - T3 Gra Rout CONin.
    - T4 PCout Yin.
    - T5 Cout Zin (ADD).
    - T6 Zlowout PCin only if con_ff = 1; otherwise no strobe, and T6 still occupies one cycle.
  - jr: T3 Gra Rout PCin.
  - in: T3 InPortout Gra Rin.
  - out: T3 Gra Rout OutPortin.
  - mfhi: T3 HIout Gra Rin.
  - mflo: T3 LOout Gra Rin.
  - nop and undefined opcodes: T3 with no strobes.
  - halt: T3 -> HALT.
- HALT: all strobes 0, run = 0, absorbing until clr.
- No two bus drivers (xxout, Rout, BAout, Cout) are ever asserted in the same cycle.
- mem_ready high in the first T1/T6/T7 cycle means zero wait states.

Decomposition:
- Package cpu_pkg holds the 5-bit opcode constants (ld = 0 through halt = 26, standard ISA map), the ALU_* codes, the state enum (RST, T0–T7, HALT) and the opcode-class enum.
- One sub-module, opcode_classifier: combinational, opcode to class.
- State register and output decode stay in control_sequencer.

Test Plan:
- Reset and first fetch:
  - Stimulus: clr pulse; mem_ready tied 1; ir = add R1,R2,R3 (0x18918000).
  - Required: RST, T0, T1, T2, T3, T4, T5 = 7 cycles, with strobes exactly as listed; T4 alu_op = 00011; back to T0.
- Memory wait states:
  - Stimulus: ld (ir = 0x00800055); mem_ready low for 3 cycles in T1 and 2 cycles in T6.
  - Required: Read held for 4 and 3 cycles; PCin high only in the first T1 cycle; T7 asserts MDRout Gra Rin.
- Branch:
  - Stimulus: br with con_ff = 0, then repeat with con_ff = 1.
  - Required: T6 has no PCin with con_ff = 0; T6 asserts Zlowout and PCin with con_ff = 1.
- mul:
  - Stimulus: ir opcode 01110.
  - Required: T5 LOin with Zlowout; T6 HIin with Zhighout; 7 execute+fetch cycles total.
- halt and reset recovery:
  - Stimulus: opcode 11010.
  - Required: run drops the cycle after T3 and state stays HALT for 20 cycles; a clr pulse returns run to 1 and fetch restarts.
- Reset mid-operation and bus exclusivity:
  - Stimulus: clr asserted asynchronously during st T6.
  - Required: all strobes 0 within the same cycle, with no Write issued.
  - Also: an assertion checks at most one bus driver asserted, every cycle.
